mem_access_unit: RTL

//  Load/store front end between EX/MEM pipeline register and word-wide data memory (MEM).

---
 rtl/lsu_defs.sv | 50 +++++
 rtl/lsu_lane.sv | 51 +++++
 rtl/mem_access_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lsu_defs.sv
`default_nettype none
// ============================================================================
// lsu_defs : funct3 codes, FSM state encoding and fault causes for mem_access_unit
// Revision : 1.0
// ============================================================================
package lsu_defs;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_EXT   = 3'd2,
    S_MERGE = 3'd3,
    S_WR    = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [2:0] FC_NONE  = 3'd0;
  localparam logic [2:0] FC_OP    = 3'd1;
  localparam logic [2:0] FC_F3    = 3'd2;
  localparam logic [2:0] FC_ALIGN = 3'd3;
  localparam logic [2:0] FC_RANGE = 3'd4;

  // Operation, funct3 and alignment checks; the range check needs the
  // address width and lives in the top.
  function automatic logic [2:0] access_cause(input logic       load,
                                              input logic       store,
                                              input logic [2:0] f3,
                                              input logic [1:0] off);
    logic legal;
    if (load == store) return FC_OP;
    legal = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = load;
      default:          legal = 1'b0;
    endcase
    if (!legal) return FC_F3;
    if ((f3[1:0] == 2'b01) && off[0]) return FC_ALIGN;
    if ((f3[1:0] == 2'b10) && (off != 2'b00)) return FC_ALIGN;
    return FC_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// lsu_lane : byte/half lane extract with sign/zero extension, and lane merge
// Revision : 1.0
// ============================================================================
module lsu_lane
  import lsu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       offset,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] merged
);

  logic [4:0]       shamt;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] new_lane;

  assign shamt    = {offset, 3'b000};
  assign shifted  = word >> shamt;
  assign new_lane = wdata << shamt;

  always_comb begin
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      F3_H:    load_data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = word;
    endcase
  end

  always_comb begin
    lane_mask = '1;
    case (funct3[1:0])
      2'b00:   lane_mask = {{(WIDTH-8){1'b0}}, 8'hFF} << shamt;
      2'b01:   lane_mask = {{(WIDTH-16){1'b0}}, 16'hFFFF} << shamt;
      default: lane_mask = '1;
    endcase
  end

  assign merged = (word & ~lane_mask) | (new_lane & lane_mask);

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : load/store front end to a word-wide memory with RMW sub-word stores
// Revision : 1.0
// ============================================================================
module mem_access_unit
  import lsu_defs::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_load,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  input  logic [4:0]       req_rd,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [4:0]       resp_rd,
  output logic             resp_fault,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_data_write,
  output logic             mem_MemWrite,
  output logic             mem_MemRead,
  input  logic [WIDTH-1:0] mem_data_read
);

  state_t               state;
  state_t               state_nx;
  logic                 cap_load;
  logic [2:0]           cap_f3;
  logic [1:0]           cap_off;
  logic [ADDR_BITS-1:0] cap_idx;
  logic [4:0]           cap_rd;
  logic [WIDTH-1:0]     wword;
  logic [WIDTH-1:0]     rdata_q;
  logic [4:0]           rd_q;
  logic                 fault_q;
  logic [2:0]           cause;
  logic                 fault;
  logic                 accept;
  logic [WIDTH-1:0]     lane_load;
  logic [WIDTH-1:0]     lane_merged;

  always_comb begin
    cause = access_cause(req_load, req_store, req_funct3, req_addr[1:0]);
    if ((cause == FC_NONE) && (req_addr[WIDTH-1:ADDR_BITS+2] != '0)) cause = FC_RANGE;
  end

  assign fault  = (cause != FC_NONE);
  assign accept = req_valid && (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    req_ready    = 1'b0;
    mem_MemRead  = 1'b0;
    mem_MemWrite = 1'b0;
    resp_valid   = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (fault)                   state_nx = S_RESP;
          else if (req_load)           state_nx = S_RD;
          else if (req_funct3 == F3_W) state_nx = S_WR;
          else                         state_nx = S_RD;
        end
      end
      S_RD: begin
        mem_MemRead = 1'b1;
        state_nx    = cap_load ? S_EXT : S_MERGE;
      end
      S_EXT:   state_nx = S_RESP;
      S_MERGE: state_nx = S_WR;
      S_WR: begin
        mem_MemWrite = 1'b1;
        state_nx     = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_nx   = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  lsu_lane #(.WIDTH(WIDTH)) u_lane (
    .word      (mem_data_read),
    .offset    (cap_off),
    .funct3    (cap_f3),
    .wdata     (wword),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  // Response registers change only on the cycle that enters RESP so they
  // hold their value between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_load <= 1'b0;
      cap_f3   <= 3'b000;
      cap_off  <= 2'b00;
      cap_idx  <= '0;
      cap_rd   <= 5'd0;
      wword    <= '0;
      rdata_q  <= '0;
      rd_q     <= 5'd0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_load <= req_load;
            cap_f3   <= req_funct3;
            cap_off  <= req_addr[1:0];
            cap_idx  <= req_addr[ADDR_BITS+1:2];
            cap_rd   <= req_rd;
            wword    <= req_wdata;
            if (fault) begin
              rdata_q <= '0;
              rd_q    <= req_rd;
              fault_q <= 1'b1;
            end
          end
        end
        S_EXT: begin
          rdata_q <= lane_load;
          rd_q    <= cap_rd;
          fault_q <= 1'b0;
        end
        S_MERGE: wword <= lane_merged;
        S_WR: begin
          rdata_q <= '0;
          rd_q    <= cap_rd;
          fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign resp_rdata     = rdata_q;
  assign resp_rd        = rd_q;
  assign resp_fault     = fault_q;
  assign mem_address    = {{(WIDTH-ADDR_BITS){1'b0}}, cap_idx};
  assign mem_data_write = wword;

endmodule
`default_nettype wire
